mac_tree_seq: RTL and testbench

Job sequencer for the fp32 MAC tree (VEC_LEN multipliers → adder tree → output accumulator). Accepts a dot-product command of N vector chunks, clears the MAC tree's accumulator, streams N operand beats into it with valid/ready backpressure, and waits out the pipeline latency. It then captures the accumulated fp32 result and holds it until the consumer takes it. Sits between the operand-fetch stream and the MAC tree; one job in flight at a time.

---
 rtl/mac_tree_seq.sv | 80 ++++++++
 tb/tb_mac_tree_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tree_seq.sv
// mac_tree_seq: one-job-at-a-time sequencer feeding operand chunks into the fp32 MAC tree and capturing its result (cmd in, op stream in, mac_* to tree, res out, rst is async active-low)
module mac_tree_seq #(
  parameter int VEC_LEN = 8,
  parameter int LEN_W = 16,
  parameter int PIPE_LAT = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic op_valid,
  output logic op_ready,
  input  logic [32*VEC_LEN-1:0] op_a,
  input  logic [32*VEC_LEN-1:0] op_b,
  output logic [32*VEC_LEN-1:0] mac_a,
  output logic [32*VEC_LEN-1:0] mac_b,
  output logic mac_acc_clr,
  input  logic [31:0] mac_out,
  output logic res_valid,
  input  logic res_ready,
  output logic [31:0] res_data,
  output logic busy
);
  localparam int DW = $clog2(PIPE_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic [DW-1:0] drain_cnt;
  logic cmd_fire, op_fire, res_fire, capture;
  assign cmd_ready = state == IDLE;
  assign op_ready = state == ISSUE;
  assign busy = state != IDLE;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign op_fire = op_valid && op_ready;
  assign res_fire = res_valid && res_ready;
  assign capture = state == DRAIN && drain_cnt == '0;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (cmd_valid) state_d = cmd_len == '0 ? DONE : CLEAR;
      CLEAR: state_d = ISSUE;
      ISSUE: if (op_fire && beat_cnt + LEN_W'(1) == len_q) state_d = DRAIN;
      DRAIN: if (drain_cnt == '0) state_d = DONE;
      DONE: if (res_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mac_acc_clr <= 1'b1;
      mac_a <= '0;
      mac_b <= '0;
      len_q <= '0;
      beat_cnt <= '0;
      drain_cnt <= '0;
      res_data <= '0;
      res_valid <= 1'b0;
    end else begin
      state <= state_d;
      mac_acc_clr <= state_d == CLEAR;
      mac_a <= op_fire ? op_a : '0;
      mac_b <= op_fire ? op_b : '0;
      if (cmd_fire) begin
        len_q <= cmd_len;
        beat_cnt <= '0;
      end else if (op_fire) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (state == ISSUE && state_d == DRAIN) drain_cnt <= DW'(PIPE_LAT);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
      if (cmd_fire && cmd_len == '0) res_data <= '0;
      else if (capture) res_data <= mac_out;
      // a zero-length job enters DONE one cycle before res_valid rises
      if (res_fire) res_valid <= 1'b0;
      else if (capture || state == DONE) res_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_tree_seq.sv
// tb_mac_tree_seq: table-driven and randomized checks of mac_tree_seq against a behavioural MAC-tree and job model
module tb_mac_tree_seq;
  localparam int VEC_LEN = 8;
  localparam int LEN_W = 16;
  localparam int PIPE_LAT = 12;
  localparam int W = 32 * VEC_LEN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid, cmd_ready, op_valid, op_ready, mac_acc_clr, res_valid, res_ready, busy;
  logic [LEN_W-1:0] cmd_len;
  logic [W-1:0] op_a, op_b, mac_a, mac_b;
  logic [31:0] mac_out = '0;
  logic [31:0] res_data;

  mac_tree_seq #(.VEC_LEN(VEC_LEN), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc_clr(mac_acc_clr), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int clr_cnt = 0;
  int last_idle = -100;
  logic [W-1:0] exp_a = '0, exp_b = '0;
  logic [31:0] vals [8] = '{32'h00000000, 32'h3F000000, 32'h3F800000, 32'h40000000,
                            32'hBF800000, 32'h3FC00000, 32'hC0000000, 32'h40400000};

  function automatic real f2r(input logic [31:0] x);
    real m;
    int e;
    if (x[30:0] == '0) return 0.0;
    e = int'(x[30:23]) - 127;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int e;
    real m;
    if (r == 0.0) return 32'h0;
    s = r < 0.0;
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  // MAC tree model: a chunk present on mac_a/mac_b in cycle k shows up in mac_out during cycle k+PIPE_LAT
  typedef struct {bit clr; real dot;} mt_t;
  mt_t pipe [$];
  mt_t ent;
  real acc = 0.0;
  real mdot;
  always @(posedge clk) begin
    mdot = 0.0;
    for (int i = 0; i < VEC_LEN; i++) mdot += f2r(mac_a[32*i +: 32]) * f2r(mac_b[32*i +: 32]);
    pipe.push_back('{mac_acc_clr, mdot});
    if (pipe.size() >= PIPE_LAT) begin
      ent = pipe.pop_front();
      acc = ent.clr ? 0.0 : acc + ent.dot;
      mac_out <= r2f(acc);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && op_valid && op_ready) hs_cnt++;
    if (rst && mac_acc_clr) clr_cnt++;
    exp_a = (rst && op_valid && op_ready) ? op_a : '0;
    exp_b = (rst && op_valid && op_ready) ? op_b : '0;
  end

  always @(negedge clk) if (rst) begin
    checks++;
    if (mac_a !== exp_a || mac_b !== exp_b) begin
      failures++;
      $display("FAIL mac_ops cyc=%0d got a=%h b=%h expected a=%h b=%h", cyc, mac_a, mac_b, exp_a, exp_b);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic recover();
    rst = 1'b0;
    op_valid = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // mode: 0 = op_valid always high, 1 = toggling, 2 = random
  task automatic job(input int len, input logic [31:0] av, input logic [31:0] bv, input int mode,
                     input bit rnd, input int hold, input bit b2b, output logic [31:0] got);
    real sum, d;
    int beats, t_acc, t_last, t_res, hs0, clr0, g;
    logic [31:0] la, lb;
    sum = 0.0;
    beats = 0;
    t_last = 0;
    got = '0;
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(len);
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    if (!cmd_ready) begin chk("cmd_accept", cmd_ready, 1); recover(); return; end
    t_acc = cyc;
    hs0 = hs_cnt;
    clr0 = clr_cnt;
    if (b2b) chk("b2b_accept", t_acc, last_idle);
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (len > 0 && beats < len && g < 1000) begin
      op_valid = mode == 0 ? 1'b1 : mode == 1 ? (g % 2 == 0) : ($urandom_range(0, 2) != 0);
      d = 0.0;
      for (int i = 0; i < VEC_LEN; i++) begin
        la = rnd ? vals[$urandom_range(0, 7)] : av;
        lb = rnd ? vals[$urandom_range(0, 7)] : bv;
        op_a[32*i +: 32] = la;
        op_b[32*i +: 32] = lb;
        d += f2r(la) * f2r(lb);
      end
      if (op_valid && op_ready) begin sum += d; beats++; t_last = cyc; end
      @(negedge clk);
      g++;
    end
    op_valid = 1'b0;
    if (beats < len) begin chk("beats", beats, len); recover(); return; end
    g = 0;
    while (!res_valid && g < 200) begin @(negedge clk); g++; end
    if (!res_valid) begin chk("res_valid_wait", res_valid, 1); recover(); return; end
    t_res = cyc;
    got = res_data;
    chk("res_data", got, r2f(sum));
    chk("latency", t_res - t_acc, len == 0 ? 2 : t_last - t_acc + PIPE_LAT + 2);
    chk("handshakes", hs_cnt - hs0, len);
    chk("clr_pulses", clr_cnt - clr0, len == 0 ? 0 : 1);
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_len = LEN_W'($urandom);
      chk("hold", {res_valid, cmd_ready, res_data}, {1'b1, 1'b0, got});
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_after_res", {cmd_ready, res_valid, busy}, 3'b100);
    last_idle = cyc;
  endtask

  typedef struct {int len; logic [31:0] a; logic [31:0] b; int mode; int hold; bit b2b; logic [31:0] exp;} vec_t;
  vec_t tbl [5];
  logic [31:0] got;
  int n, g;

  initial begin
    cmd_valid = 1'b0;
    cmd_len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    tbl[0] = '{1, 32'h3F800000, 32'h40000000, 0, 10, 1'b0, 32'h41800000};
    tbl[1] = '{1, 32'h3F800000, 32'h3F000000, 0, 0, 1'b1, 32'h40800000};
    tbl[2] = '{4, 32'h3F800000, 32'h3F800000, 1, 2, 1'b0, 32'h42000000};
    tbl[3] = '{0, 32'h3F800000, 32'h3F800000, 0, 1, 1'b1, 32'h00000000};
    tbl[4] = '{3, 32'h40000000, 32'hBF800000, 0, 0, 1'b0, 32'hC2400000};
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr", mac_acc_clr, 1);
    chk("rst_res", {res_valid, res_data}, 33'h0);
    chk("rst_mac_ops", |{mac_a, mac_b}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("clr_after_release", mac_acc_clr, 0);
    for (int k = 0; k < 5; k++) begin
      job(tbl[k].len, tbl[k].a, tbl[k].b, tbl[k].mode, 1'b0, tbl[k].hold, tbl[k].b2b, got);
      chk("tbl_data", got, tbl[k].exp);
    end
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(4);
    @(negedge clk);
    cmd_valid = 1'b0;
    op_valid = 1'b1;
    op_a = {VEC_LEN{32'h3F800000}};
    op_b = {VEC_LEN{32'h3F800000}};
    n = 0;
    g = 0;
    while (n < 2 && g < 20) begin
      if (op_ready) n++;
      @(negedge clk);
      g++;
    end
    chk("mid_beats", n, 2);
    chk("mid_op_ready", op_ready, 1);
    rst = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("mid_rst_outputs", {res_valid, op_ready, mac_acc_clr, busy, cmd_ready}, 5'b00101);
    chk("mid_rst_mac_ops", |{mac_a, mac_b}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    job(1, 32'h3F800000, 32'h3F000000, 0, 1'b0, 0, 1'b0, got);
    chk("post_rst_data", got, 32'h40800000);
    for (int k = 0; k < 12; k++) begin
      job($urandom_range(0, 6), '0, '0, 2, 1'b1, $urandom_range(0, 3), 1'b0, got);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
